// File: rtl/tone_synth.sv
// tone_synth: debounced eight-key single-voice square-wave tone generator.
// Ports: clk, rst (sync, active-high), key[7:0], octave[1:0] in;
//        wave, note[3:0], active, half_period[CNT_W-1:0] out.
module tone_synth #(
  parameter int TICK_DIV      = 50,
  parameter int DEBOUNCE      = 20000,
  parameter int RELEASE_TICKS = 100000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       key,
  input  logic [1:0]       octave,
  output logic             wave,
  output logic [3:0]       note,
  output logic             active,
  output logic [CNT_W-1:0] half_period
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    REL
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [3:0]       last_q, last_d;
  logic [DW-1:0]    db_q, db_d;
  logic [3:0]       stable_q, stable_d;
  logic [RW-1:0]    rel_q, rel_d;
  logic [CNT_W-1:0] tone_q, tone_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic             wave_q, wave_d;
  logic [3:0]       note_q, note_d;

  logic             tick;
  logic [3:0]       cand;
  logic [3:0]       sound_note;
  logic [CNT_W-1:0] pending;

  function automatic logic [CNT_W-1:0] half_of(
    input logic [3:0] n,
    input logic [1:0] oct
  );
    logic [CNT_W-1:0] b;
    case (n)
      4'd1:    b = CNT_W'(1908);
      4'd2:    b = CNT_W'(1701);
      4'd3:    b = CNT_W'(1515);
      4'd4:    b = CNT_W'(1433);
      4'd5:    b = CNT_W'(1276);
      4'd6:    b = CNT_W'(1136);
      4'd7:    b = CNT_W'(1012);
      4'd8:    b = CNT_W'(956);
      default: b = '0;
    endcase
    case (oct)
      2'd1:    return b >> 1;
      2'd2:    return b << 1;
      default: return b;
    endcase
  endfunction

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Lowest set key wins; scan high to low so the lowest overwrites.
  always_comb begin
    cand = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (s2_q[i]) cand = 4'(i + 1);
    end
  end

  // The note that will sound next: a fresh key, else the held one.
  assign sound_note = (stable_q != 4'd0) ? stable_q : note_q;
  assign pending    = half_of(sound_note, octave);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    s1_d       = key;
    s2_d       = s1_q;
    last_d     = last_q;
    db_d       = db_q;
    stable_d   = stable_q;
    rel_d      = rel_q;
    tone_d     = tone_q;
    cur_half_d = cur_half_q;
    wave_d     = wave_q;
    note_d     = note_q;

    if (tick) begin
      last_d = cand;
      if (cand != last_q) begin
        db_d = '0;
      end else if (db_q != DW'(DEBOUNCE)) begin
        db_d = db_q + DW'(1);
      end
      if (db_d == DW'(DEBOUNCE)) stable_d = cand;
    end

    case (state_q)
      IDLE: begin
        if (stable_q != 4'd0) begin
          state_d    = PLAY;
          note_d     = stable_q;
          tone_d     = '0;
          wave_d     = 1'b0;
          cur_half_d = pending;
        end
      end
      default: begin
        // Pitch changes only land on a toggle, so half-cycles stay whole.
        if (tick) begin
          if (tone_q == cur_half_q - CNT_W'(1)) begin
            wave_d     = ~wave_q;
            tone_d     = '0;
            cur_half_d = pending;
          end else begin
            tone_d = tone_q + CNT_W'(1);
          end
        end
        if (state_q == PLAY) begin
          if (stable_q != 4'd0) begin
            note_d = stable_q;
          end else begin
            state_d = REL;
            rel_d   = '0;
          end
        end else begin
          if (stable_q != 4'd0) begin
            state_d = PLAY;
            note_d  = stable_q;
          end else if (tick) begin
            if (rel_q == RW'(RELEASE_TICKS - 1)) begin
              state_d    = IDLE;
              note_d     = 4'd0;
              wave_d     = 1'b0;
              cur_half_d = '0;
              tone_d     = '0;
              rel_d      = '0;
            end else begin
              rel_d = rel_q + RW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      last_q     <= '0;
      db_q       <= '0;
      stable_q   <= '0;
      rel_q      <= '0;
      tone_q     <= '0;
      cur_half_q <= '0;
      wave_q     <= 1'b0;
      note_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      last_q     <= last_d;
      db_q       <= db_d;
      stable_q   <= stable_d;
      rel_q      <= rel_d;
      tone_q     <= tone_d;
      cur_half_q <= cur_half_d;
      wave_q     <= wave_d;
      note_q     <= note_d;
    end
  end

  assign wave        = wave_q;
  assign note        = note_q;
  assign active      = (state_q != IDLE);
  assign half_period = cur_half_q;

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed bench for tone_synth.
// Small params: TICK_DIV=2, DEBOUNCE=3, RELEASE_TICKS=10.
module tb_tone_synth;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key;
  logic [1:0]  octave;
  logic        wave;
  logic [3:0]  note;
  logic        active;
  logic [15:0] half_period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edge_cyc = 0;

  tone_synth #(
    .TICK_DIV     (2),
    .DEBOUNCE     (3),
    .RELEASE_TICKS(10),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .octave     (octave),
    .wave       (wave),
    .note       (note),
    .active     (active),
    .half_period(half_period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_edge(input int budget, output bit ok);
    logic prev;
    prev = wave;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wave !== prev) begin
        ok = 1'b1;
        edge_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic wait_active(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (active === v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int t0;
    rst = 1'b1;
    key = 8'h01;
    octave = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({wave, note, active, half_period} !== 22'd0) begin
        errors++;
        $display("FAIL reset_out cyc%0d got w=%b n=%0d a=%b hp=%0d want 0",
                 i, wave, note, active, half_period);
      end
    end
    rst = 1'b0;
    t0 = cyc;
    repeat (4) @(negedge clk);
    checks++;
    if (note !== 4'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_early_note got n=%0d a=%b want 0 0", note, active);
    end
  endtask

  task automatic test_single_key();
    bit ok;
    int t0, t1, lat;
    t0 = cyc - 4;
    wait_active(1'b1, 40, ok);
    lat = cyc - t0;
    checks++;
    if (!ok || lat < 9 || lat > 13) begin
      errors++;
      $display("FAIL key_latency got ok=%0d lat=%0d want 9..13", ok, lat);
    end
    checks++;
    if (note !== 4'd1 || half_period !== 16'd1908 || wave !== 1'b0) begin
      errors++;
      $display("FAIL single_note got n=%0d hp=%0d w=%b want 1 1908 0",
               note, half_period, wave);
    end
    t1 = cyc;
    wait_edge(5000, ok);
    checks++;
    if (!ok || (edge_cyc - t1) < 3814 || (edge_cyc - t1) > 3818) begin
      errors++;
      $display("FAIL first_edge got ok=%0d dt=%0d want 3814..3818",
               ok, edge_cyc - t1);
    end
    t1 = edge_cyc;
    wait_edge(5000, ok);
    checks++;
    if (!ok || (edge_cyc - t1) != 3816) begin
      errors++;
      $display("FAIL base_period got ok=%0d dt=%0d want 3816",
               ok, edge_cyc - t1);
    end
    key = 8'h00;
    wait_active(1'b0, 200, ok);
    checks++;
    if (!ok || wave !== 1'b0 || note !== 4'd0 || half_period !== 16'd0) begin
      errors++;
      $display("FAIL single_idle got ok=%0d w=%b n=%0d hp=%0d want 1 0 0 0",
               ok, wave, note, half_period);
    end
  endtask

  task automatic test_priority_octave();
    bit ok;
    int e;
    key = 8'h0A;
    wait_active(1'b1, 40, ok);
    checks++;
    if (!ok || note !== 4'd2 || half_period !== 16'd1701) begin
      errors++;
      $display("FAIL prio_note got ok=%0d n=%0d hp=%0d want 1 2 1701",
               ok, note, half_period);
    end
    wait_edge(4000, ok);
    e = edge_cyc;
    repeat (300) @(negedge clk);
    octave = 2'd1;
    @(negedge clk);
    checks++;
    if (half_period !== 16'd1701) begin
      errors++;
      $display("FAIL oct_hold got hp=%0d want 1701", half_period);
    end
    wait_edge(5000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 3402 || half_period !== 16'd850) begin
      errors++;
      $display("FAIL oct_cur_half got ok=%0d dt=%0d hp=%0d want 1 3402 850",
               ok, edge_cyc - e, half_period);
    end
    e = edge_cyc;
    wait_edge(5000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 1700) begin
      errors++;
      $display("FAIL oct_high got ok=%0d dt=%0d want 1700", ok, edge_cyc - e);
    end
    e = edge_cyc;
    repeat (200) @(negedge clk);
    octave = 2'd2;
    wait_edge(5000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 1700 || half_period !== 16'd3402) begin
      errors++;
      $display("FAIL oct_low_switch got ok=%0d dt=%0d hp=%0d want 1 1700 3402",
               ok, edge_cyc - e, half_period);
    end
    e = edge_cyc;
    wait_edge(8000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 6804) begin
      errors++;
      $display("FAIL oct_low got ok=%0d dt=%0d want 6804", ok, edge_cyc - e);
    end
    octave = 2'd0;
    key = 8'h00;
    wait_active(1'b0, 200, ok);
    checks++;
    if (!ok || wave !== 1'b0) begin
      errors++;
      $display("FAIL oct_idle got ok=%0d w=%b want 1 0", ok, wave);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    seen = 1'b0;
    key = 8'h80;
    repeat (4) @(negedge clk);
    key = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (note !== 4'd0 || wave !== 1'b0 || active !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bounce got note/wave activity want none");
    end
  endtask

  task automatic test_release();
    bit ok;
    bit held;
    int t0, dur;
    key = 8'h20;
    wait_active(1'b1, 40, ok);
    checks++;
    if (!ok || note !== 4'd6 || half_period !== 16'd1136) begin
      errors++;
      $display("FAIL rel_note got ok=%0d n=%0d hp=%0d want 1 6 1136",
               ok, note, half_period);
    end
    repeat (50) @(negedge clk);
    key = 8'h00;
    t0 = cyc;
    held = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (active === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (note !== 4'd6) held = 1'b0;
    end
    dur = cyc - t0;
    checks++;
    if (!ok || !held || dur < 24 || dur > 38) begin
      errors++;
      $display("FAIL rel_duration got ok=%0d held=%0d dt=%0d want 1 1 24..38",
               ok, held, dur);
    end
    checks++;
    if (note !== 4'd0 || wave !== 1'b0 || half_period !== 16'd0) begin
      errors++;
      $display("FAIL rel_idle got n=%0d w=%b hp=%0d want 0 0 0",
               note, wave, half_period);
    end
  endtask

  task automatic test_repress();
    bit ok;
    int e;
    key = 8'h20;
    wait_active(1'b1, 40, ok);
    wait_edge(3000, ok);
    e = edge_cyc;
    checks++;
    if (!ok || wave !== 1'b1) begin
      errors++;
      $display("FAIL rep_first_edge got ok=%0d w=%b want 1 1", ok, wave);
    end
    key = 8'h00;
    repeat (14) @(negedge clk);
    checks++;
    if (active !== 1'b1 || note !== 4'd6) begin
      errors++;
      $display("FAIL rep_releasing got a=%b n=%0d want 1 6", active, note);
    end
    key = 8'h04;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (note === 4'd3) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || wave !== 1'b1 || active !== 1'b1 || half_period !== 16'd1136) begin
      errors++;
      $display("FAIL rep_play got ok=%0d w=%b a=%b hp=%0d want 1 1 1 1136",
               ok, wave, active, half_period);
    end
    wait_edge(3000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 2272 || half_period !== 16'd1515) begin
      errors++;
      $display("FAIL rep_toggle got ok=%0d dt=%0d hp=%0d want 1 2272 1515",
               ok, edge_cyc - e, half_period);
    end
    e = edge_cyc;
    wait_edge(4000, ok);
    checks++;
    if (!ok || (edge_cyc - e) != 3030) begin
      errors++;
      $display("FAIL rep_pitch got ok=%0d dt=%0d want 3030", ok, edge_cyc - e);
    end
    key = 8'h00;
    wait_active(1'b0, 200, ok);
    checks++;
    if (!ok || note !== 4'd0) begin
      errors++;
      $display("FAIL rep_idle got ok=%0d n=%0d want 1 0", ok, note);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_priority_octave();
    test_bounce();
    test_release();
    test_repress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
